// File: rtl/piece_fall_ctrl.sv
// Falling-piece controller: gravity timer, button moves and spawn, with every
// candidate position confirmed through an external collision query handshake.
`timescale 1ns/1ps
module piece_fall_ctrl #(
  parameter int TICK_DIV = 25000000,
  parameter int BOARD_W  = 10,
  parameter int BOARD_H  = 20,
  parameter int SPAWN_X  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  output logic       coll_req,
  output logic [4:0] coll_x,
  output logic [4:0] coll_y,
  input  logic       coll_ack,
  input  logic       coll_hit,
  output logic [4:0] current_x,
  output logic [4:0] current_y,
  output logic       tick,
  output logic       lock_valid,
  output logic       game_over
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0] X_MAX   = 5'(BOARD_W - 1);
  localparam logic [4:0] Y_MAX   = 5'(BOARD_H - 1);
  localparam logic [4:0] SPAWN_V = 5'(SPAWN_X);

  localparam logic [2:0] ST_FALL  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_LOCK  = 3'd2;
  localparam logic [2:0] ST_SPAWN = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic [2:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             tick_r, tick_s;
  logic             pend_r, pend_s;
  logic [4:0]       cur_x_r, cur_x_s, cur_y_r, cur_y_s;
  logic             req_r, req_s;
  logic [4:0]       qx_r, qx_s, qy_r, qy_s;
  logic             vert_r, vert_s;
  logic             lock_r, lock_s;
  logic             over_r, over_s;
  logic             grav_s, drop_s;

  // Next-state logic: timer, pending gravity, FALL arbitration and query resolution
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    cur_x_s = cur_x_r;
    cur_y_s = cur_y_r;
    req_s   = req_r;
    qx_s    = qx_r;
    qy_s    = qy_r;
    vert_s  = vert_r;
    lock_s  = 1'b0;
    over_s  = over_r;
    grav_s  = tick_r | pend_r;
    drop_s  = grav_s | btn_down;

    if (state_r == ST_OVER) begin
      cnt_s = cnt_r;
    end else if (cnt_r == CNT_MAX) begin
      cnt_s = CNT_ZERO;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end

    // Ticks seen while busy collapse into a single pending step
    if ((state_r != ST_FALL) && tick_r) begin
      pend_s = 1'b1;
    end else begin
      pend_s = pend_r;
    end

    case (state_r)
      ST_FALL: begin
        if (drop_s) begin
          pend_s = 1'b0;
          if (cur_y_r == Y_MAX) begin
            state_s = ST_LOCK;
            lock_s  = 1'b1;
          end else begin
            state_s = ST_CHECK;
            req_s   = 1'b1;
            qx_s    = cur_x_r;
            qy_s    = cur_y_r + 5'd1;
            vert_s  = 1'b1;
          end
        end else if (btn_left) begin
          if (cur_x_r != 5'd0) begin
            state_s = ST_CHECK;
            req_s   = 1'b1;
            qx_s    = cur_x_r - 5'd1;
            qy_s    = cur_y_r;
            vert_s  = 1'b0;
          end else begin
            state_s = ST_FALL;
          end
        end else if (btn_right) begin
          if (cur_x_r != X_MAX) begin
            state_s = ST_CHECK;
            req_s   = 1'b1;
            qx_s    = cur_x_r + 5'd1;
            qy_s    = cur_y_r;
            vert_s  = 1'b0;
          end else begin
            state_s = ST_FALL;
          end
        end else begin
          state_s = ST_FALL;
        end
      end
      ST_CHECK: begin
        if (coll_ack) begin
          req_s = 1'b0;
          if (!coll_hit) begin
            cur_x_s = qx_r;
            cur_y_s = qy_r;
            state_s = ST_FALL;
          end else if (vert_r) begin
            state_s = ST_LOCK;
            lock_s  = 1'b1;
          end else begin
            state_s = ST_FALL;
          end
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_LOCK: begin
        state_s = ST_SPAWN;
        req_s   = 1'b1;
        qx_s    = SPAWN_V;
        qy_s    = 5'd0;
        vert_s  = 1'b0;
      end
      ST_SPAWN: begin
        if (coll_ack) begin
          req_s = 1'b0;
          if (coll_hit) begin
            state_s = ST_OVER;
            over_s  = 1'b1;
          end else begin
            cur_x_s = SPAWN_V;
            cur_y_s = 5'd0;
            state_s = ST_FALL;
          end
        end else begin
          state_s = ST_SPAWN;
        end
      end
      ST_OVER: begin
        state_s = ST_OVER;
        req_s   = 1'b0;
        over_s  = 1'b1;
      end
      default: begin
        state_s = ST_FALL;
        req_s   = 1'b0;
      end
    endcase

    // Tick is registered, so predict it from the counter and state being loaded
    tick_s = (state_s != ST_OVER) && (cnt_s == CNT_MAX);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FALL;
      cnt_r   <= CNT_ZERO;
      tick_r  <= 1'b0;
      pend_r  <= 1'b0;
      cur_x_r <= SPAWN_V;
      cur_y_r <= 5'd0;
      req_r   <= 1'b0;
      qx_r    <= 5'd0;
      qy_r    <= 5'd0;
      vert_r  <= 1'b0;
      lock_r  <= 1'b0;
      over_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tick_r  <= tick_s;
      pend_r  <= pend_s;
      cur_x_r <= cur_x_s;
      cur_y_r <= cur_y_s;
      req_r   <= req_s;
      qx_r    <= qx_s;
      qy_r    <= qy_s;
      vert_r  <= vert_s;
      lock_r  <= lock_s;
      over_r  <= over_s;
    end
  end

  assign coll_req   = req_r;
  assign coll_x     = qx_r;
  assign coll_y     = qy_r;
  assign current_x  = cur_x_r;
  assign current_y  = cur_y_r;
  assign tick       = tick_r;
  assign lock_valid = lock_r;
  assign game_over  = over_r;

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Scoreboard bench for piece_fall_ctrl: expected queries and locks are queued as
// stimulus is applied and matched in order as the DUT emits them.
`timescale 1ns/1ps
module tb_piece_fall_ctrl;

  localparam int TICK_DIV = 4;
  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int SPAWN_X  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
  logic       coll_ack = 1'b0, coll_hit = 1'b0;
  logic       coll_req, tick, lock_valid, game_over;
  logic [4:0] coll_x, coll_y, current_x, current_y;

  // Collision model controls
  logic       hit_all = 1'b0;
  logic [4:0] hit_col = 5'd31;
  int         resp_delay = 0;
  logic       ack_stray = 1'b0;

  typedef struct packed {
    logic       lock;
    logic [4:0] x;
    logic [4:0] y;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  piece_fall_ctrl #(
    .TICK_DIV(TICK_DIV), .BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .SPAWN_X(SPAWN_X)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .coll_req(coll_req), .coll_x(coll_x), .coll_y(coll_y),
    .coll_ack(coll_ack), .coll_hit(coll_hit),
    .current_x(current_x), .current_y(current_y),
    .tick(tick), .lock_valid(lock_valid), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_q(input int x, input int y);
    sb.push_back({1'b0, 5'(x), 5'(y)});
  endtask

  task automatic push_l(input int x, input int y);
    sb.push_back({1'b1, 5'(x), 5'(y)});
  endtask

  task automatic sb_compare(input string tag, input ev_t obs);
    ev_t e;
    check_eq({tag, "_expected"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq(tag, 32'(obs), 32'(e));
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 64);
    if (!tick) check_eq("tick_timeout", 32'(tick), 32'd1);
  endtask

  task automatic wait_req(input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (coll_req !== lvl && n < 100);
    if (coll_req !== lvl) check_eq("req_timeout", 32'(coll_req), 32'(lvl));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
    hit_all = 1'b0; hit_col = 5'd31; resp_delay = 0; ack_stray = 1'b0;
    #1;
    check_eq("rst_x", 32'(current_x), 32'(SPAWN_X));
    check_eq("rst_y", 32'(current_y), 32'd0);
    check_eq("rst_req", 32'(coll_req), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_lock", 32'(lock_valid), 32'd0);
    check_eq("rst_over", 32'(game_over), 32'd0);
    check_eq("rst_cx", 32'(coll_x), 32'd0);
    check_eq("rst_cy", 32'(coll_y), 32'd0);
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    rst = 1'b1;
  endtask

  // Collision responder: acks after resp_delay cycles of coll_req
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (ack_stray) begin
        coll_ack = 1'b1;
        coll_hit = 1'b1;
        wait_cnt = 0;
      end else if (coll_ack) begin
        coll_ack = 1'b0;
        coll_hit = 1'b0;
      end else if (coll_req) begin
        if (wait_cnt >= resp_delay) begin
          coll_ack = 1'b1;
          coll_hit = hit_all || (coll_x == hit_col);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: new queries and lock pulses go to the scoreboard; held queries must be stable
  initial begin
    logic       prev_req = 1'b0;
    logic [4:0] cap_x = 5'd0, cap_y = 5'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
      end else begin
        if (coll_req && !prev_req) begin
          sb_compare("query", {1'b0, coll_x, coll_y});
          cap_x = coll_x;
          cap_y = coll_y;
        end else if (coll_req) begin
          check_eq("req_x_stable", 32'(coll_x), 32'(cap_x));
          check_eq("req_y_stable", 32'(coll_y), 32'(cap_y));
        end
        if (lock_valid) sb_compare("lock", {1'b1, current_x, current_y});
        prev_req = coll_req;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bx, by, act;
    #2;

    // Gravity to the floor, lock without query, respawn
    do_reset();
    for (int k = 1; k <= BOARD_H - 1; k++) push_q(SPAWN_X, k);
    push_l(SPAWN_X, BOARD_H - 1);
    push_q(SPAWN_X, 0);
    push_q(SPAWN_X, 1);
    wait_tick();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    check_eq("tick_period", 32'(n), 32'(TICK_DIV));
    wait_drain(200);
    check_eq("respawn_x", 32'(current_x), 32'(SPAWN_X));
    check_eq("respawn_y", 32'(current_y), 32'd0);

    // Left presses down to the wall; the last one is dropped without a query
    do_reset();
    bx = SPAWN_X; by = 0;
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      by++;
      push_q(bx, by);
      @(negedge clk);
      @(negedge clk);
      btn_left = 1'b1;
      if (bx > 0) begin
        bx--;
        push_q(bx, by);
      end
      @(negedge clk);
      btn_left = 1'b0;
    end
    check_eq("left_wall_noreq", 32'(coll_req), 32'd0);
    wait_tick();
    by++;
    push_q(bx, by);
    wait_drain(20);
    check_eq("left_wall_x", 32'(current_x), 32'd0);

    // Gravity beats a simultaneous left press
    do_reset();
    wait_tick();
    btn_left = 1'b1;
    push_q(SPAWN_X, 1);
    @(negedge clk);
    btn_left = 1'b0;
    wait_tick();
    push_q(SPAWN_X, 2);
    wait_drain(20);
    check_eq("prio_x", 32'(current_x), 32'(SPAWN_X));

    // Lateral move into an occupied cell is discarded
    do_reset();
    hit_col = 5'(SPAWN_X + 1);
    wait_tick();
    push_q(SPAWN_X, 1);
    @(negedge clk);
    @(negedge clk);
    btn_right = 1'b1;
    push_q(SPAWN_X + 1, 1);
    @(negedge clk);
    btn_right = 1'b0;
    wait_tick();
    push_q(SPAWN_X, 2);
    wait_drain(20);
    check_eq("lat_hit_x", 32'(current_x), 32'(SPAWN_X));

    // Reset in the middle of a query, then a stray ack after release
    do_reset();
    resp_delay = 50;
    wait_tick();
    push_q(SPAWN_X, 1);
    wait_req(1'b1, n);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midq_rst_req", 32'(coll_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ack_stray = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_stray = 1'b0;
    resp_delay = 0;
    #1;
    check_eq("stray_req", 32'(coll_req), 32'd0);
    check_eq("stray_y", 32'(current_y), 32'd0);
    check_eq("stray_lock", 32'(lock_valid), 32'd0);
    wait_tick();
    push_q(SPAWN_X, 1);
    wait_drain(20);

    // Slow ack: held query, ignored button, pending gravity collapses to one step
    do_reset();
    resp_delay = 11;
    wait_tick();
    push_q(SPAWN_X, 1);
    wait_req(1'b1, n);
    @(negedge clk);
    btn_left = 1'b1;
    @(negedge clk);
    btn_left = 1'b0;
    wait_req(1'b0, n);
    resp_delay = 0;
    push_q(SPAWN_X, 2);
    wait_req(1'b1, n);
    check_eq("pend_gap", 32'(n), 32'd1);
    wait_req(1'b0, n);
    push_q(SPAWN_X, 3);
    wait_req(1'b1, n);
    check_eq("collapse_gap", 32'(n), 32'd2);
    wait_drain(20);
    check_eq("busy_btn_x", 32'(current_x), 32'(SPAWN_X));

    // Down hit locks, blocked spawn ends the game until reset
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      push_q(SPAWN_X, k);
    end
    @(negedge clk);
    @(negedge clk);
    hit_all = 1'b1;
    btn_down = 1'b1;
    push_q(SPAWN_X, 6);
    push_l(SPAWN_X, 5);
    push_q(SPAWN_X, 0);
    @(negedge clk);
    btn_down = 1'b0;
    n = 0;
    while (!game_over && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("game_over_set", 32'(game_over), 32'd1);
    wait_drain(10);
    act = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      act += int'(coll_req) + int'(tick) + int'(lock_valid);
    end
    check_eq("over_quiet", 32'(act), 32'd0);
    check_eq("game_over_sticky", 32'(game_over), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("over_rst_flag", 32'(game_over), 32'd0);
    check_eq("over_rst_x", 32'(current_x), 32'(SPAWN_X));
    check_eq("over_rst_y", 32'(current_y), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_fall_ctrl.md
PIECE_FALL_CTRL -- requirements
Module: piece_fall_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, clocks per gravity step (minimum 2).
REQ-002 SHALL have parameter BOARD_W, default 10, board columns.
REQ-003 SHALL have parameter BOARD_H, default 20, board rows.
REQ-004 SHALL have parameter SPAWN_X, default 4, spawn column.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk and rst, as below.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 btn_left  input  1  single-cycle move-left request.
REQ-009 btn_right  input  1  single-cycle move-right request.
REQ-010 btn_down  input  1  single-cycle soft-drop request.
REQ-011 coll_req  output  1  collision query valid.
REQ-012 coll_x  output  5  queried column.
REQ-013 coll_y  output  5  queried row.
REQ-014 coll_ack  input  1  query answered this cycle.
REQ-015 coll_hit  input  1  queried cell occupied; valid only with coll_ack.
REQ-016 current_x  output  5  committed piece column.
REQ-017 current_y  output  5  committed piece row (0 = top).
REQ-018 tick  output  1  one-cycle gravity pulse.
REQ-019 lock_valid  output  1  one-cycle pulse: piece locked at current_x/current_y.
REQ-020 game_over  output  1  sticky spawn-blocked flag.

Function
REQ-021 SHALL implement states FALL, CHECK, LOCK, SPAWN, OVER.
REQ-022 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick=1 in the cycle the counter equals TICK_DIV-1; the counter SHALL run in every state except OVER.
REQ-023 A tick outside FALL SHALL set a gravity-pending flag; the flag SHALL clear when gravity is serviced, and multiple ticks SHALL collapse into one pending step.
REQ-024 In FALL, service priority SHALL be: gravity (tick or pending) > btn_down > btn_left > btn_right; at most one move per service; unserviced buttons SHALL be dropped.
REQ-025 Buttons arriving in any state other than FALL SHALL be ignored (not queued).
REQ-026 Left at current_x=0 or right at current_x=BOARD_W-1 SHALL be discarded in FALL without a query.
REQ-027 Gravity or down at current_y=BOARD_H-1 SHALL go directly to LOCK without a query.
REQ-028 Otherwise FALL SHALL go to CHECK, with coll_req=1 and coll_x/coll_y = candidate cell from the next cycle.
REQ-029 coll_req, coll_x and coll_y SHALL hold stable until the cycle coll_ack=1; coll_req SHALL drop the following cycle.
REQ-030 CHECK resolution: coll_hit=0 SHALL commit the candidate to current_x/current_y on the edge ending the ack cycle, then return to FALL.
REQ-031 CHECK resolution: coll_hit=1 on a vertical move SHALL go to LOCK.
REQ-032 CHECK resolution: coll_hit=1 on a lateral move SHALL discard the move and return to FALL.
REQ-033 LOCK SHALL last one cycle with lock_valid=1 and current_x/current_y unchanged, then go to SPAWN.
REQ-034 SPAWN SHALL query cell (SPAWN_X,0) per REQ-029.
REQ-035 On SPAWN miss, SHALL set current_x=SPAWN_X, current_y=0 and go to FALL.
REQ-036 On SPAWN hit, SHALL go to OVER; game_over=1 until reset; in OVER no query, no lock, tick=0.
REQ-037 Coordinates SHALL be 5-bit unsigned; no wrap: left never below 0, right never above BOARD_W-1, y never above BOARD_H-1.
REQ-038 coll_ack while coll_req=0 SHALL be ignored.

Reset
REQ-039 rst=0 SHALL immediately force: state FALL, current_x=SPAWN_X, current_y=0, tick counter 0, pending 0, coll_req=0, lock_valid=0, tick=0, game_over=0, coll_x=0, coll_y=0.
REQ-040 Reset mid-query SHALL abandon the query; a late coll_ack after release SHALL be ignored per REQ-038.

Verification (TICK_DIV=4, BOARD_H=20, SPAWN_X=4)
REQ-041 Release rst, collision model always miss, no buttons -> tick every 4th cycle; current_y steps 0,1,2... one per tick; at y=19 next tick -> lock_valid pulse at (4,19), no coll_req for that step, then respawn at (4,0).
REQ-042 btn_left x5 spaced 6 cycles from x=4 -> x=3,2,1,0, fifth press yields no coll_req and x stays 0.
REQ-043 btn_left and tick in the same FALL cycle -> gravity queried (4,1); left dropped; x stays 4.
REQ-044 Hold coll_ack low 10 cycles during a query -> coll_req/coll_x/coll_y stable for all 10; ticks inside set pending; after ack, next FALL cycle issues a gravity query immediately.
REQ-045 coll_hit=1 on the down query from (4,5) -> lock_valid at (4,5); spawn query (4,0) hit -> game_over=1, no further coll_req; rst pulse -> game_over=0, position (4,0).
